// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register for the 5-stage MIPS core: carries PC, payload and hazard info,
// with stall/flush control, on-stage hazard compare and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W            = 128,
    parameter int unsigned TNEW_W            = 4,
    parameter bit          TNEW_DEC          = 1'b1,
    parameter bit          TNEW_DEC_ON_STALL = 1'b0,
    parameter bit          KEEP_PC_ON_FLUSH  = 1'b1,
    parameter logic [31:0] RESET_PC          = 32'h0000_3000,
    parameter int unsigned CNT_W             = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [4:0]        in_dst_addr,
    input  logic              in_wr_en,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [4:0]        src_a_addr,
    input  logic [4:0]        src_b_addr,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_payload,
    output logic [4:0]        out_dst_addr,
    output logic              out_wr_en,
    output logic [TNEW_W-1:0] out_tnew,
    output logic              hit_a,
    output logic              hit_b,
    output logic              fwd_ok_a,
    output logic              fwd_ok_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [TNEW_W-1:0] TNEW_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [TNEW_W-1:0] tnew_q;
    logic              stall_inc;
    logic              bubble_inc;

    // Tnew seen downstream is one cycle closer to ready; floor at zero so it never wraps.
    always_comb begin
        out_tnew = tnew_q;
        if (TNEW_DEC && (tnew_q != '0)) begin
            out_tnew = tnew_q - TNEW_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_payload  <= '0;
            out_dst_addr <= 5'd0;
            out_wr_en    <= 1'b0;
            tnew_q       <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_pc       <= KEEP_PC_ON_FLUSH ? in_pc : 32'd0;
            out_payload  <= '0;
            out_dst_addr <= 5'd0;
            out_wr_en    <= 1'b0;
            tnew_q       <= '0;
        end else if (enable) begin
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_payload  <= in_payload;
            out_dst_addr <= in_dst_addr;
            out_wr_en    <= in_wr_en;
            tnew_q       <= in_tnew;
        end else if (TNEW_DEC_ON_STALL) begin
            tnew_q       <= out_tnew;
        end
    end

    // Register 0 is hardwired, so it is never a forwarding source.
    assign hit_a    = out_valid && out_wr_en && (out_dst_addr != 5'd0) && (out_dst_addr == src_a_addr);
    assign hit_b    = out_valid && out_wr_en && (out_dst_addr != 5'd0) && (out_dst_addr == src_b_addr);
    assign fwd_ok_a = hit_a && (out_tnew == '0);
    assign fwd_ok_b = hit_b && (out_tnew == '0);

    assign stall_inc  = !flush && !enable && out_valid;
    assign bubble_inc = flush || (enable && !in_valid);

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance and one with stall-decrement,
// zeroed flush PC and 4-bit counters, driven by the same stimulus.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset, enable, flush, clr_cnt;
    logic         in_valid, in_wr_en;
    logic [31:0]  in_pc;
    logic [127:0] in_payload;
    logic [4:0]   in_dst_addr, src_a_addr, src_b_addr;
    logic [3:0]   in_tnew;

    logic         out_valid0, out_wr_en0, hit_a0, hit_b0, fwd_ok_a0, fwd_ok_b0;
    logic [31:0]  out_pc0;
    logic [127:0] out_payload0;
    logic [4:0]   out_dst_addr0;
    logic [3:0]   out_tnew0;
    logic [15:0]  stall_cnt0, bubble_cnt0;

    logic         out_valid1, out_wr_en1, hit_a1, hit_b1, fwd_ok_a1, fwd_ok_b1;
    logic [31:0]  out_pc1;
    logic [127:0] out_payload1;
    logic [4:0]   out_dst_addr1;
    logic [3:0]   out_tnew1;
    logic [3:0]   stall_cnt1, bubble_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] P1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
        .in_dst_addr(in_dst_addr), .in_wr_en(in_wr_en), .in_tnew(in_tnew),
        .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .out_valid(out_valid0), .out_pc(out_pc0), .out_payload(out_payload0),
        .out_dst_addr(out_dst_addr0), .out_wr_en(out_wr_en0), .out_tnew(out_tnew0),
        .hit_a(hit_a0), .hit_b(hit_b0), .fwd_ok_a(fwd_ok_a0), .fwd_ok_b(fwd_ok_b0),
        .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
    );

    pipe_stage_reg #(.TNEW_DEC_ON_STALL(1'b1), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
        .in_dst_addr(in_dst_addr), .in_wr_en(in_wr_en), .in_tnew(in_tnew),
        .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .out_valid(out_valid1), .out_pc(out_pc1), .out_payload(out_payload1),
        .out_dst_addr(out_dst_addr1), .out_wr_en(out_wr_en1), .out_tnew(out_tnew1),
        .hit_a(hit_a1), .hit_b(hit_b1), .fwd_ok_a(fwd_ok_a1), .fwd_ok_b(fwd_ok_b1),
        .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b0; in_wr_en = 1'b0; in_pc = 32'd0; in_payload = '0;
        in_dst_addr = 5'd0; in_tnew = 4'd0; src_a_addr = 5'd0; src_b_addr = 5'd0;

        // reset state
        cyc(); cyc();
        chk("rst_valid",  128'(out_valid0),  128'(1'b0));
        chk("rst_pc",     128'(out_pc0),     128'(32'h3000));
        chk("rst_pc1",    128'(out_pc1),     128'(32'h3000));
        chk("rst_tnew",   128'(out_tnew0),   128'(4'd0));
        chk("rst_stall",  128'(stall_cnt0),  128'(16'd0));
        chk("rst_bubble", 128'(bubble_cnt0), 128'(16'd0));
        chk("rst_hit_a",  128'(hit_a0),      128'(1'b0));

        // load with tnew=2, then tnew=1
        reset = 1'b0; enable = 1'b1; in_valid = 1'b1; in_pc = 32'h3004; in_dst_addr = 5'd5;
        in_wr_en = 1'b1; in_tnew = 4'd2; in_payload = P1; src_a_addr = 5'd5; src_b_addr = 5'd6;
        cyc();
        chk("ld_valid",   128'(out_valid0), 128'(1'b1));
        chk("ld_pc",      128'(out_pc0),    128'(32'h3004));
        chk("ld_payload", out_payload0,     P1);
        chk("ld_tnew",    128'(out_tnew0),  128'(4'd1));
        chk("ld_hit_a",   128'(hit_a0),     128'(1'b1));
        chk("ld_fwd_a",   128'(fwd_ok_a0),  128'(1'b0));
        chk("ld_hit_b",   128'(hit_b0),     128'(1'b0));
        in_tnew = 4'd1; in_pc = 32'h3008;
        cyc();
        chk("ld2_tnew",   128'(out_tnew0),  128'(4'd0));
        chk("ld2_fwd_a",  128'(fwd_ok_a0),  128'(1'b1));
        src_b_addr = 5'd5;
        #1;
        chk("ld2_fwd_b",  128'(fwd_ok_b0),  128'(1'b1));

        // load tnew=3 then hold 3 cycles
        in_tnew = 4'd3; in_pc = 32'h300c;
        cyc();
        chk("h0_tnew0", 128'(out_tnew0), 128'(4'd2));
        chk("h0_tnew1", 128'(out_tnew1), 128'(4'd2));
        enable = 1'b0;
        cyc();
        chk("h1_tnew0", 128'(out_tnew0), 128'(4'd2));
        chk("h1_tnew1", 128'(out_tnew1), 128'(4'd1));
        chk("h1_pc",    128'(out_pc0),   128'(32'h300c));
        cyc();
        chk("h2_tnew1", 128'(out_tnew1), 128'(4'd0));
        cyc();
        chk("h3_tnew1", 128'(out_tnew1), 128'(4'd0));
        chk("h3_valid", 128'(out_valid0),  128'(1'b1));
        chk("h3_stall0", 128'(stall_cnt0), 128'(16'd3));
        chk("h3_stall1", 128'(stall_cnt1), 128'(4'd3));
        chk("h3_bubble", 128'(bubble_cnt0), 128'(16'd0));

        // flush wins over enable
        flush = 1'b1; enable = 1'b1; in_pc = 32'h3010;
        cyc();
        chk("fl_valid",   128'(out_valid0),    128'(1'b0));
        chk("fl_dst",     128'(out_dst_addr0), 128'(5'd0));
        chk("fl_wr_en",   128'(out_wr_en0),    128'(1'b0));
        chk("fl_payload", out_payload0,        128'd0);
        chk("fl_tnew",    128'(out_tnew0),     128'(4'd0));
        chk("fl_pc0",     128'(out_pc0),       128'(32'h3010));
        chk("fl_pc1",     128'(out_pc1),       128'(32'h0));
        chk("fl_bubble0", 128'(bubble_cnt0),   128'(16'd1));
        chk("fl_bubble1", 128'(bubble_cnt1),   128'(4'd1));
        chk("fl_stall",   128'(stall_cnt0),    128'(16'd3));

        // enable with in_valid=0 loads as-is and counts a bubble
        flush = 1'b0; in_valid = 1'b0; in_pc = 32'h3014; in_tnew = 4'd0; src_a_addr = 5'd5;
        cyc();
        chk("iv_valid",  128'(out_valid0),    128'(1'b0));
        chk("iv_dst",    128'(out_dst_addr0), 128'(5'd5));
        chk("iv_pc",     128'(out_pc0),       128'(32'h3014));
        chk("iv_hit_a",  128'(hit_a0),        128'(1'b0));
        chk("iv_bubble", 128'(bubble_cnt0),   128'(16'd2));

        // register 0 never hits
        in_valid = 1'b1; in_dst_addr = 5'd0; src_a_addr = 5'd0; in_pc = 32'h3018;
        cyc();
        chk("r0_valid", 128'(out_valid0), 128'(1'b1));
        chk("r0_hit_a", 128'(hit_a0),     128'(1'b0));

        // bubble counter saturation on the 4-bit instance
        flush = 1'b1;
        repeat (15) cyc();
        chk("sat_bubble1", 128'(bubble_cnt1), 128'(4'hf));
        chk("sat_bubble0", 128'(bubble_cnt0), 128'(16'd17));

        // stall counter saturation
        flush = 1'b0; enable = 1'b1; in_dst_addr = 5'd5; src_a_addr = 5'd5; in_pc = 32'h301c;
        cyc();
        enable = 1'b0;
        repeat (14) cyc();
        chk("sat_stall1", 128'(stall_cnt1), 128'(4'hf));
        chk("sat_stall0", 128'(stall_cnt0), 128'(16'd17));

        // clr_cnt beats a same-cycle increment, pipeline untouched
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        chk("clr_stall0",  128'(stall_cnt0),  128'(16'd0));
        chk("clr_stall1",  128'(stall_cnt1),  128'(4'd0));
        chk("clr_bubble0", 128'(bubble_cnt0), 128'(16'd0));
        chk("clr_bubble1", 128'(bubble_cnt1), 128'(4'd0));
        chk("clr_valid",   128'(out_valid0),  128'(1'b1));
        chk("clr_pc",      128'(out_pc0),     128'(32'h301c));

        // reset mid-hold
        repeat (7) cyc();
        chk("pre_rst_stall", 128'(stall_cnt0), 128'(16'd7));
        reset = 1'b1;
        cyc();
        chk("mr_valid",   128'(out_valid0),    128'(1'b0));
        chk("mr_pc",      128'(out_pc0),       128'(32'h3000));
        chk("mr_dst",     128'(out_dst_addr0), 128'(5'd0));
        chk("mr_wr_en",   128'(out_wr_en0),    128'(1'b0));
        chk("mr_payload", out_payload0,        128'd0);
        chk("mr_stall",   128'(stall_cnt0),    128'(16'd0));
        chk("mr_pc1",     128'(out_pc1),       128'(32'h3000));

        // reset beats flush
        flush = 1'b1; in_pc = 32'h3020;
        cyc();
        chk("rf_pc0",    128'(out_pc0),     128'(32'h3000));
        chk("rf_pc1",    128'(out_pc1),     128'(32'h3000));
        chk("rf_bubble", 128'(bubble_cnt0), 128'(16'd0));
        reset = 1'b0; flush = 1'b0; enable = 1'b0;
        cyc();
        chk("post_stall", 128'(stall_cnt0), 128'(16'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
